// File: rtl/rr_mux_sequencer.sv
// Round-robin burst sequencer for a 16-input bus multiplexer: grants one channel at a time
// for up to maxBeats accepted beats and drives registered sel/enable for the mux.
module rr_mux_sequencer #(
    parameter int unsigned maxBeats = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    input  logic [15:0] req,
    input  logic        xferLast,
    input  logic        outReady,
    output logic [3:0]  sel,
    output logic        enable,
    output logic        outValid,
    output logic [15:0] ack,
    output logic        busy
);

    typedef enum logic [0:0] {StIdle, StXfer} state_e;

    state_e      r_state, w_state_d;
    logic [3:0]  r_sel, w_sel_d;
    logic [3:0]  r_ptr, w_ptr_d;
    logic [7:0]  r_cnt, w_cnt_d;

    logic        w_xfer;
    logic        w_live;
    logic        w_req_sel;
    logic [15:0] w_sel_onehot;
    logic        w_beat;
    logic        w_last_beat;
    logic        w_release;
    logic [3:0]  w_base;
    logic [15:0] w_cand;
    logic [3:0]  w_win;
    logic        w_found;

    assign w_xfer       = (r_state == StXfer);
    // Beats are suppressed while reset is asserted so an aborted burst never acks.
    assign w_live       = w_xfer & reset;
    assign w_req_sel    = req[r_sel];
    assign w_sel_onehot = 16'(1) << r_sel;
    assign w_beat       = w_live & w_req_sel & outReady;
    assign w_last_beat  = (r_cnt == 8'(maxBeats - 1));
    assign w_release    = (w_beat & (xferLast | w_last_beat)) | ~w_req_sel;

    // In XFER the search starts after the current channel and excludes it.
    assign w_base = w_xfer ? r_sel : r_ptr;
    assign w_cand = w_xfer ? (req & ~w_sel_onehot) : req;

    // Descending offsets so the nearest requester after w_base is written last.
    always_comb begin
        logic [3:0] w_idx;
        w_idx   = '0;
        w_win   = w_base;
        w_found = 1'b0;
        for (int i = 16; i >= 1; i--) begin
            w_idx = w_base + 4'(i);
            if (w_cand[w_idx]) begin
                w_win   = w_idx;
                w_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_sel_d   = r_sel;
        w_ptr_d   = r_ptr;
        w_cnt_d   = r_cnt;
        unique case (r_state)
            StIdle: begin
                if (run && w_found) begin
                    w_state_d = StXfer;
                    w_sel_d   = w_win;
                    w_ptr_d   = w_win;
                    w_cnt_d   = '0;
                end
            end
            StXfer: begin
                if (w_release) begin
                    if (run && w_found) begin
                        w_sel_d = w_win;
                        w_ptr_d = w_win;
                        w_cnt_d = '0;
                    end else if (run && w_req_sel) begin
                        w_ptr_d = r_sel;
                        w_cnt_d = '0;
                    end else begin
                        w_state_d = StIdle;
                    end
                end else if (w_beat) begin
                    w_cnt_d = r_cnt + 8'd1;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= StIdle;
            r_sel   <= '0;
            r_ptr   <= 4'd15;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_d;
            r_sel   <= w_sel_d;
            r_ptr   <= w_ptr_d;
            r_cnt   <= w_cnt_d;
        end
    end

    assign sel      = r_sel;
    assign enable   = w_xfer;
    assign busy     = w_xfer;
    assign outValid = w_live & w_req_sel;
    assign ack      = w_beat ? w_sel_onehot : 16'h0000;

endmodule
